// File: rtl/bnn_eval_sequencer.sv
// -----------------------------------------------------------------------------
// bnn_eval_sequencer
//
// Runs a stored test set through a combinational BNN classifier. For each
// vector it reads the features and the expected label from a synchronous test
// memory, drives the features onto the classifier for SETTLE_CYCLES cycles,
// captures the prediction, and offers one result per vector on a valid/ready
// stream. A running count of correctly classified vectors is kept per run.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           single-cycle run request, honoured only while idle
//   abort           synchronous cancel, any state, wins over start
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse when a run completes normally
//   mem_rd          test-memory read strobe
//   mem_addr        vector index presented to the test memory
//   mem_feat        feature vector, valid the cycle after mem_rd
//   mem_label       expected class, same timing as mem_feat
//   features        registered drive to the classifier
//   prediction      classifier output (combinational from features)
//   res_valid       result available
//   res_ready       consumer accepts the result
//   res_index       vector index of the result
//   res_pred        captured prediction
//   res_correct     prediction matched the label and is a legal class
//   correct_cnt     correct results accepted in the current or last run
// -----------------------------------------------------------------------------
module bnn_eval_sequencer #(
    parameter int FEAT_CNT      = 12,
    parameter int FEAT_BITS     = 4,
    parameter int CLASS_CNT     = 6,
    parameter int TEST_CNT      = 1000,
    parameter int SETTLE_CYCLES = 2,
    localparam int CW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1,
    localparam int AW = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1,
    localparam int NW = $clog2(TEST_CNT + 1),
    localparam int FW = FEAT_CNT * FEAT_BITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [FW-1:0] mem_feat,
    input  logic [CW-1:0] mem_label,
    output logic [FW-1:0] features,
    input  logic [CW-1:0] prediction,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_index,
    output logic [CW-1:0] res_pred,
    output logic          res_correct,
    output logic [NW-1:0] correct_cnt
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          state, state_nxt;

    logic [AW-1:0]   idx;
    logic [CW-1:0]   label;
    logic [SW-1:0]   settle_cnt;

    logic            run_start;
    logic            vec_load;
    logic            settle_step;
    logic            pred_capture;
    logic            res_accept;
    logic            last_vec;

    // A prediction outside the class range never counts as correct, even if
    // the stored label happens to carry the same out-of-range code.
    function automatic logic is_correct(input logic [CW-1:0] pred,
                                        input logic [CW-1:0] lbl);
        return (pred == lbl) && (32'(pred) < 32'(CLASS_CNT));
    endfunction

    assign last_vec = (idx == AW'(TEST_CNT - 1));
    assign mem_addr = idx;

    // ---- control: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- control: next state, strobes and stream outputs ----
    always_comb begin
        state_nxt    = state;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        mem_rd       = 1'b0;
        res_valid    = 1'b0;
        run_start    = 1'b0;
        vec_load     = 1'b0;
        settle_step  = 1'b0;
        pred_capture = 1'b0;
        res_accept   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    run_start = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd    = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                vec_load  = 1'b1;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                settle_step = 1'b1;
                if (settle_cnt == SW'(1)) begin
                    pred_capture = 1'b1;
                    state_nxt    = S_EMIT;
                end
            end
            S_EMIT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_accept = 1'b1;
                    state_nxt  = last_vec ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort cancels every datapath update of this cycle, including a
        // handshake that would otherwise complete, and suppresses done.
        if (abort) begin
            state_nxt    = S_IDLE;
            done         = 1'b0;
            run_start    = 1'b0;
            vec_load     = 1'b0;
            settle_step  = 1'b0;
            pred_capture = 1'b0;
            res_accept   = 1'b0;
        end
    end

    // ---- datapath: vector load, settle timing, capture and scoring ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            correct_cnt <= '0;
            features    <= '0;
            label       <= '0;
            settle_cnt  <= '0;
            res_pred    <= '0;
            res_index   <= '0;
            res_correct <= 1'b0;
        end else begin
            if (run_start) begin
                idx         <= '0;
                correct_cnt <= '0;
            end

            if (vec_load) begin
                features   <= mem_feat;
                label      <= mem_label;
                settle_cnt <= SW'(SETTLE_CYCLES);
            end else if (settle_step) begin
                settle_cnt <= settle_cnt - SW'(1);
            end

            if (pred_capture) begin
                res_pred    <= prediction;
                res_index   <= idx;
                res_correct <= is_correct(prediction, label);
            end

            if (res_accept) begin
                if (res_correct) begin
                    correct_cnt <= correct_cnt + NW'(1);
                end
                if (!last_vec) begin
                    idx <= idx + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_eval_sequencer.sv
module tb_bnn_eval_sequencer;

    localparam int FEAT_CNT      = 12;
    localparam int FEAT_BITS     = 4;
    localparam int CLASS_CNT     = 6;
    localparam int TEST_CNT      = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int FW            = FEAT_CNT * FEAT_BITS;
    localparam int CW            = 3;
    localparam int AW            = 2;
    localparam int NW            = 3;
    localparam int PERIOD        = SETTLE_CYCLES + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [FW-1:0] mem_feat = '0;
    logic [CW-1:0] mem_label = '0;
    logic [FW-1:0] features;
    logic [CW-1:0] prediction;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [AW-1:0] res_index;
    logic [CW-1:0] res_pred;
    logic          res_correct;
    logic [NW-1:0] correct_cnt;

    // test memory contents and classifier stub configuration
    logic [FW-1:0] feat_mem  [TEST_CNT];
    logic [CW-1:0] label_mem [TEST_CNT];
    logic          force_en  = 1'b0;
    logic [CW-1:0] force_val = '0;

    // scoreboard / model state
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_idx = 0;
    int model_cnt = 0;
    int first_valid = -1;
    int done_cnt = 0;
    int done_cyc = 0;
    int n_rd = 0;
    int stalls = 0;
    logic [TEST_CNT-1:0] corr_seq = '0;
    logic mon_en = 1'b0;

    // ready driver configuration
    int   stall_idx = -1;
    int   stall_left = 0;
    logic rand_rdy = 1'b0;

    bnn_eval_sequencer #(
        .FEAT_CNT     (FEAT_CNT),
        .FEAT_BITS    (FEAT_BITS),
        .CLASS_CNT    (CLASS_CNT),
        .TEST_CNT     (TEST_CNT),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_feat   (mem_feat),
        .mem_label  (mem_label),
        .features   (features),
        .prediction (prediction),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_index  (res_index),
        .res_pred   (res_pred),
        .res_correct(res_correct),
        .correct_cnt(correct_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous test memory: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_feat  <= feat_mem[mem_addr];
            mem_label <= label_mem[mem_addr];
        end
    end

    // combinational classifier stub
    assign prediction = force_en ? force_val : (features[2:0] % 3'd6);

    // ---------------- reference model ----------------
    function automatic logic [CW-1:0] ref_pred(input int i);
        if (force_en) return force_val;
        return feat_mem[i][2:0] % 3'd6;
    endfunction

    function automatic logic ref_ok(input int i);
        logic [CW-1:0] p;
        p = ref_pred(i);
        return (p == label_mem[i]) && (int'(p) < CLASS_CNT);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                res_ready = 1'($urandom_range(0, 1));
            end else if (res_valid && int'(res_index) == stall_idx && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (busy) chk("correct_cnt", 64'(correct_cnt), 64'(model_cnt));
            if (mem_rd) begin
                chk("mem_addr", 64'(mem_addr), 64'(exp_idx));
                n_rd++;
            end
            if (res_valid) begin
                if (first_valid < 0) first_valid = cyc - start_cyc;
                if (exp_idx >= TEST_CNT) begin
                    chk("res_valid_after_last", 64'(res_valid), 64'(0));
                end else begin
                    chk("res_index",   64'(res_index),   64'(exp_idx));
                    chk("res_pred",    64'(res_pred),    64'(ref_pred(exp_idx)));
                    chk("res_correct", 64'(res_correct), 64'(ref_ok(exp_idx)));
                    chk("features",    64'(features),    64'(feat_mem[exp_idx]));
                    if (res_ready) begin
                        corr_seq[exp_idx] = res_correct;
                        model_cnt += int'(ref_ok(exp_idx));
                        exp_idx++;
                    end else begin
                        stalls++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_all", 64'(exp_idx), 64'(TEST_CNT));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic init_model();
        exp_idx     = 0;
        model_cnt   = 0;
        first_valid = -1;
        done_cnt    = 0;
        n_rd        = 0;
        stalls      = 0;
        corr_seq    = '0;
        mon_en      = 1'b1;
    endtask

    task automatic fill_mem(input int mode);
        // mode 0: labels match, 1: mismatch at odd indices, 2: random labels
        for (int i = 0; i < TEST_CNT; i++) begin
            feat_mem[i] = {16'($urandom), 32'($urandom)};
            if (mode == 2)
                label_mem[i] = 3'($urandom_range(0, 7));
            else if (mode == 1 && (i % 2) == 1)
                label_mem[i] = (ref_pred(i) + 3'd1) % 3'd6;
            else
                label_mem[i] = ref_pred(i);
        end
    endtask

    task automatic do_run(input int s_idx, input int s_len, input logic rnd,
                          input logic mid_start, output int len);
        stall_idx  = s_idx;
        stall_left = s_len;
        rand_rdy   = rnd;
        init_model();
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int k = 0; k < 300 && done_cnt == 0; k++) begin
            @(posedge clk);
            #1;
            start = (mid_start && cyc == start_cyc + 8);
        end
        start = 1'b0;
        chk("done_seen", 64'(done_cnt), 64'(1));
        len = done_cyc - start_cyc;
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("rd_count", 64'(n_rd), 64'(TEST_CNT));
        rand_rdy  = 1'b0;
        stall_idx = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  len;
        logic found;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",        64'(busy),        64'(0));
        chk("rst_done",        64'(done),        64'(0));
        chk("rst_mem_rd",      64'(mem_rd),      64'(0));
        chk("rst_mem_addr",    64'(mem_addr),    64'(0));
        chk("rst_features",    64'(features),    64'(0));
        chk("rst_res_valid",   64'(res_valid),   64'(0));
        chk("rst_res_index",   64'(res_index),   64'(0));
        chk("rst_res_pred",    64'(res_pred),    64'(0));
        chk("rst_res_correct", 64'(res_correct), 64'(0));
        chk("rst_correct_cnt", 64'(correct_cnt), 64'(0));
        rst_n = 1'b1;

        // A: all labels match
        fill_mem(0);
        do_run(-1, 0, 1'b0, 1'b0, len);
        chk("A_len",         64'(len),         64'(21));
        chk("A_first_valid", 64'(first_valid), 64'(5));
        chk("A_model_cnt",   64'(model_cnt),   64'(4));
        chk("A_correct_cnt", 64'(correct_cnt), 64'(4));

        // B: mismatches at indices 1 and 3
        fill_mem(1);
        do_run(-1, 0, 1'b0, 1'b0, len);
        chk("B_corr_seq",    64'(corr_seq),    64'(4'b0101));
        chk("B_correct_cnt", 64'(correct_cnt), 64'(2));
        repeat (5) @(posedge clk);
        #1;
        chk("B_cnt_hold",    64'(correct_cnt), 64'(2));

        // C: backpressure of 7 cycles on index 2
        fill_mem(0);
        do_run(2, 7, 1'b0, 1'b0, len);
        chk("C_len",         64'(len),         64'(28));
        chk("C_stalls",      64'(stalls),      64'(7));
        chk("C_correct_cnt", 64'(correct_cnt), 64'(4));

        // D: out-of-range prediction 7 with label 7
        force_en  = 1'b1;
        force_val = 3'd7;
        for (int i = 0; i < TEST_CNT; i++) label_mem[i] = 3'd7;
        do_run(-1, 0, 1'b0, 1'b0, len);
        chk("D_res_pred",    64'(res_pred),    64'(7));
        chk("D_res_correct", 64'(res_correct), 64'(0));
        chk("D_correct_cnt", 64'(correct_cnt), 64'(0));
        force_en = 1'b0;

        // E: abort during SETTLE of index 1
        fill_mem(0);
        init_model();
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("E_busy_in_settle", 64'(busy), 64'(1));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("E_busy_after_abort",  64'(busy),      64'(0));
        chk("E_valid_after_abort", 64'(res_valid), 64'(0));
        repeat (10) @(posedge clk);
        #1;
        chk("E_no_done",     64'(done_cnt),    64'(0));
        chk("E_correct_cnt", 64'(correct_cnt), 64'(1));

        // abort wins over start while idle
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_over_start_busy", 64'(busy),        64'(0));
        chk("abort_over_start_cnt",  64'(correct_cnt), 64'(1));

        // F: random data, random backpressure, start pulsed mid-run
        for (int r = 0; r < 3; r++) begin
            fill_mem(2);
            do_run(-1, 0, 1'b1, 1'b1, len);
            chk("F_len",         64'(len),         64'(TEST_CNT * PERIOD + 1 + stalls));
            chk("F_correct_cnt", 64'(correct_cnt), 64'(model_cnt));
        end

        // G: reset pulsed mid-EMIT, then a fresh run replays from index 0
        fill_mem(0);
        init_model();
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #2;
            if (res_valid && res_index == 2'd2) found = 1'b1;
        end
        chk("G_reached_emit", 64'(found), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("G_rst_busy",        64'(busy),        64'(0));
        chk("G_rst_res_valid",   64'(res_valid),   64'(0));
        chk("G_rst_mem_rd",      64'(mem_rd),      64'(0));
        chk("G_rst_features",    64'(features),    64'(0));
        chk("G_rst_res_index",   64'(res_index),   64'(0));
        chk("G_rst_res_pred",    64'(res_pred),    64'(0));
        chk("G_rst_correct_cnt", 64'(correct_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_run(-1, 0, 1'b0, 1'b0, len);
        chk("G_len",         64'(len),         64'(21));
        chk("G_correct_cnt", 64'(correct_cnt), 64'(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
